// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with an iterative unsigned multiply/divide unit,
// architectural HI/LO registers and valid/ready handshakes on both sides.
// Single-cycle ops complete at the accept edge. MULTU and DIVU (non-zero
// divisor) take WIDTH further edges, one shift-add or shift-subtract step
// per edge.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;
  localparam logic [3:0] OP_XOR   = 4'b1100;
  localparam logic [3:0] OP_NOR   = 4'b1101;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q;
  // Multiplicand (MUL) or divisor (DIV).
  logic [WIDTH-1:0]  opnd_q;
  // MUL: {acc_hi, acc_lo} is the shifting partial product / multiplier.
  // DIV: acc_hi is the partial remainder, acc_lo shifts dividend out and
  // quotient bits in.
  logic [WIDTH-1:0]  acc_hi_q, acc_lo_q;

  logic              accept;
  logic              last_step;
  logic              start_iter;
  logic              is_div;
  logic              load_res;
  logic              load_hilo;
  logic [WIDTH-1:0]  res_d, hi_d, lo_d;
  logic [WIDTH-1:0]  alu_res;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift, div_diff;
  logic [WIDTH-1:0]  step_hi, step_lo;

  assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign last_step = (cnt_q == CNTW'(WIDTH - 1));
  assign is_div    = (ctrl == OP_DIVU);

  // Single-cycle ALU result for the incoming operation.
  always_comb begin
    unique case (ctrl)
      OP_AND:  alu_res = data1 & data2;
      OP_OR:   alu_res = data1 | data2;
      OP_ADD:  alu_res = data1 + data2;
      OP_SUB:  alu_res = data1 - data2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_XOR:  alu_res = data1 ^ data2;
      OP_NOR:  alu_res = ~(data1 | data2);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // One multiply or divide iteration applied to the current accumulators.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    step_hi   = acc_hi_q;
    step_lo   = acc_lo_q;
    if (state_q == MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else if (state_q == DIV) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Next-state and completion decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // hold its old value, which is what would otherwise infer a latch.
    state_d    = state_q;
    start_iter = 1'b0;
    load_res   = 1'b0;
    load_hilo  = 1'b0;
    res_d      = '0;
    hi_d       = hi;
    lo_d       = lo;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctrl == OP_MULTU) begin
            state_d    = MUL;
            start_iter = 1'b1;
          end else if (is_div && (data2 != '0)) begin
            state_d    = DIV;
            start_iter = 1'b1;
          end else if (is_div) begin
            load_res  = 1'b1;
            res_d     = '1;
            load_hilo = 1'b1;
            hi_d      = data1;
            lo_d      = '1;
          end else begin
            load_res = 1'b1;
            res_d    = alu_res;
          end
        end
      end
      MUL, DIV: begin
        if (last_step) begin
          state_d   = IDLE;
          load_res  = 1'b1;
          res_d     = step_lo;
          load_hilo = 1'b1;
          hi_d      = step_hi;
          lo_d      = step_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked blocks use non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath, output and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the iteration registers are cleared along with the outputs so
      // an aborted multiply/divide leaves nothing behind.
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
    end else begin
      if (start_iter) begin
        opnd_q   <= is_div ? data2 : data1;
        acc_lo_q <= is_div ? data1 : data2;
        acc_hi_q <= '0;
        cnt_q    <= '0;
      end else if (state_q != IDLE) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        cnt_q    <= cnt_q + CNTW'(1);
      end

      if (load_res) begin
        result    <= res_d;
        zero      <= (res_d == '0);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (load_hilo) begin
        hi <= hi_d;
        lo <= lo_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: the stimulus process pushes the expected
// response of each issued op, monitor processes pop and compare whenever an
// output handshake occurs. A WIDTH=8 instance covers the small-width case.
module tb_alu_muldiv;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [31:0] data1, data2, result, hi, lo;
  logic [3:0]  ctrl;

  logic        in_valid8, in_ready8, out_valid8, zero8, busy8;
  logic [7:0]  data1_8, data2_8, result8, hi8, lo8;
  logic [3:0]  ctrl8;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t q[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .ctrl(ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .busy(busy)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .data1(data1_8), .data2(data2_8), .ctrl(ctrl8), .out_valid(out_valid8),
    .out_ready(out_ready), .result(result8), .zero(zero8), .hi(hi8), .lo(lo8),
    .busy(busy8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] res,
                              input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.tag = tag;
    e.res = res;
    e.z   = (res == 32'd0);
    e.hi  = h;
    e.lo  = l;
    return e;
  endfunction

  // Drive one op, wait (bounded) for acceptance, optionally record its
  // expected response. Returns at posedge+1 after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    ctrl     = c;
    data1    = a;
    data2    = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check({e.tag, "_accept_timeout"}, 32'd0, 32'd1);
    end else if (push) begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    ctrl     = 4'b1111;
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got result %h with no pending op", result);
      end else begin
        e = q.pop_front();
        check({e.tag, "_result"}, result, e.res);
        check({e.tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
        check({e.tag, "_hi"}, hi, e.hi);
        check({e.tag, "_lo"}, lo, e.lo);
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid8 && out_ready) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output8: got result %h with no pending op", result8);
      end else begin
        e = q8.pop_front();
        check({e.tag, "_result"}, {24'd0, result8}, e.res);
        check({e.tag, "_hi"}, {24'd0, hi8}, e.hi);
        check({e.tag, "_lo"}, {24'd0, lo8}, e.lo);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_bad;
    int n;
    int raise_cyc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data1     = '0;
    data2     = '0;
    ctrl      = 4'b1111;
    in_valid8 = 1'b0;
    data1_8   = '0;
    data2_8   = '0;
    ctrl8     = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-cycle sweep with 14, 9.
    issue(4'b0000, 32'd14, 32'd9, mk("and", 32'd8, 0, 0), 1'b1);
    check("and_lat1", {31'd0, out_valid}, 32'd1);
    issue(4'b0001, 32'd14, 32'd9, mk("or", 32'd15, 0, 0), 1'b1);
    issue(4'b0010, 32'd14, 32'd9, mk("add", 32'd23, 0, 0), 1'b1);
    issue(4'b0110, 32'd14, 32'd9, mk("sub", 32'd5, 0, 0), 1'b1);
    issue(4'b0111, 32'd14, 32'd9, mk("slt", 32'd0, 0, 0), 1'b1);
    issue(4'b1100, 32'd14, 32'd9, mk("xor", 32'd7, 0, 0), 1'b1);
    issue(4'b1101, 32'd14, 32'd9, mk("nor", 32'hFFFF_FFF0, 0, 0), 1'b1);
    issue(4'b1111, 32'd14, 32'd9, mk("nop", 32'd0, 0, 0), 1'b1);
    issue(4'b0011, 32'd14, 32'd9, mk("undef", 32'd0, 0, 0), 1'b1);

    // Signed compare and negative wrap.
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, mk("slt_neg", 32'd1, 0, 0), 1'b1);
    issue(4'b0111, 32'd1, 32'hFFFF_FFFF, mk("slt_swap", 32'd0, 0, 0), 1'b1);
    issue(4'b0110, 32'd9, 32'd14, mk("sub_neg", 32'hFFFF_FFFB, 0, 0), 1'b1);

    // MULTU latency, busy and in_ready while iterating.
    issue(4'b1000, 32'hFFFF_FFFF, 32'd2, mk("multu", 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE), 1'b1);
    data1    = 32'h1234_5678;
    data2    = 32'd0;
    lat      = 1;
    busy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready || !busy) busy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    check("multu_latency", lat, 32'd33);
    check("multu_busy_stall", busy_bad, 32'd0);
    issue(4'b1010, 32'd0, 32'd0, mk("mfhi", 32'd1, 32'd1, 32'hFFFF_FFFE), 1'b1);
    issue(4'b1011, 32'd0, 32'd0, mk("mflo", 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE), 1'b1);

    // DIVU, normal and by zero.
    issue(4'b1001, 32'd100, 32'd7, mk("divu", 32'd14, 32'd2, 32'd14), 1'b1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("divu_latency", lat, 32'd33);
    issue(4'b1001, 32'd100, 32'd0, mk("divu0", 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF), 1'b1);
    check("divu0_lat1", {31'd0, out_valid}, 32'd1);

    // Backpressure: hold result, stall next op, accept once out_ready rises.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(4'b0010, 32'd3, 32'd4, mk("add_bp", 32'd7, 32'd100, 32'hFFFF_FFFF), 1'b1);
    fork
      issue(4'b0000, 32'd3, 32'd6, mk("and_after_bp", 32'd2, 32'd100, 32'hFFFF_FFFF), 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_result", result, 32'd7);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        raise_cyc = cyc;
        out_ready = 1'b1;
      end
    join
    check("bp_accept_cycle", acc_cyc, raise_cyc + 1);

    // Reset 10 cycles into a MULTU: nothing is produced for it.
    issue(4'b1000, 32'd5, 32'd6, mk("multu_abort", 0, 0, 0), 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    issue(4'b1010, 32'd0, 32'd0, mk("mfhi_after_rst", 32'd0, 32'd0, 32'd0), 1'b1);

    // WIDTH=8 instance: 0xFF * 0xFF = 0xFE01.
    @(negedge clk);
    check("w8_in_ready", {31'd0, in_ready8}, 32'd1);
    in_valid8 = 1'b1;
    ctrl8     = 4'b1000;
    data1_8   = 8'hFF;
    data2_8   = 8'hFF;
    q8.push_back(mk("w8_multu", 32'h01, 32'hFE, 32'h01));
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w8_multu_latency", lat, 32'd9);

    // Drain both scoreboards (bounded).
    n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check("drain", q.size() + q8.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised successor to the single-cycle datapath ALU. It keeps the existing ctrl encodings and adds an iterative unsigned multiply/divide unit with architectural HI/LO registers, MFHI and MFLO reads, and a valid/ready handshake on both input and output. It sits in the EX stage of the MIPS pipeline. The hazard/stall logic uses in_ready and out_valid to hold the pipeline during multi-cycle operations.

Parameters:
WIDTH, 32, datapath width of data1, data2, result, hi and lo; must be >= 4.
CNTW, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand/ctrl present
in_ready  out  1  block can accept an operation this cycle
data1  in  WIDTH  operand A (rs)
data2  in  WIDTH  operand B (rt)
ctrl  in  4  operation select
out_valid  out  1  result/zero valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
zero  out  1  registered (result == 0)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  multiply/divide iteration in progress

Behaviour:
- Reset values: result=0, zero=1, out_valid=0, hi=0, lo=0, busy=0, state=IDLE.
- Reset asserted mid-operation aborts the operation and clears all registers. No output is produced for the aborted operation.
- Operation codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 XOR, 1101 NOR.
  - 0111 SLT: signed two's-complement compare; result is 1 or 0.
  - 1000 MULTU, 1001 DIVU.
  - 1010 MFHI (result=hi), 1011 MFLO (result=lo).
  - 1111 NOP and all undefined codes: result=0.
- ADD/SUB wrap modulo 2^WIDTH. No overflow flag.
- Accept condition: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This gives full throughput for single-cycle ops when out_ready is held high.
- FSM states:
  - IDLE: on accept of a single-cycle op, load result/zero and set out_valid at that edge (latency 1). Stay in IDLE.
  - IDLE, MULTU accepted: latch operands, counter=0, go to MUL, busy=1.
  - IDLE, DIVU accepted with data2!=0: latch operands, go to DIV, busy=1.
  - IDLE, DIVU accepted with data2==0: complete in 1 cycle with hi=data1, lo=all ones, result=all ones.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the edge ending the last step, write the 2*WIDTH product to {hi,lo}, set result=lo, out_valid=1, busy=0, and go to IDLE.
  - DIV: restoring shift-subtract, one quotient bit per cycle for WIDTH cycles. On the final edge, lo=quotient, hi=remainder, result=quotient, out_valid=1, busy=0, and go to IDLE.
- Multi-cycle latency: accept edge to out_valid is exactly WIDTH+1 edges for MULTU and for DIVU with non-zero divisor.
- Output hold: result, zero and out_valid are held stable while out_valid && !out_ready.
- out_valid clears on an edge with out_ready=1, unless a new result loads at that same edge (then it stays 1 with the new data).
- hi/lo change only on MULTU/DIVU completion. Single-cycle ops and MFHI/MFLO never modify them.
- MFHI/MFLO issued immediately after MULTU/DIVU completion return the new values. No forwarding hazard exists, because in_ready is low while busy.
- Operands are latched at accept; data1/data2/ctrl changes during MUL/DIV have no effect.
- zero is always computed from the WIDTH-bit result written in the same cycle.

Test Plan:
1. WIDTH=32, data1=14, data2=9, out_ready=1, ctrl sweep 0000,0001,0010,0110,0111,1100,1101,1111 -> results 8, 15, 23, 5, 0, 7, 0xFFFFFFF0, 0. Each valid 1 cycle after accept; zero=1 only for SLT and NOP.
2. SLT with data1=0xFFFFFFFF, data2=1 -> result=1. Swapped operands -> 0. SUB 9-14 -> 0xFFFFFFFB, zero=0.
3. MULTU 0xFFFFFFFF*2 -> out_valid exactly 33 edges after accept, hi=1, lo=0xFFFFFFFE, result=0xFFFFFFFE, in_ready=0 and busy=1 throughout. Then MFHI -> 1 and MFLO -> 0xFFFFFFFE.
4. DIVU 100/7 -> lo=14, hi=2 after 33 edges. DIVU 100/0 -> 1 cycle later: hi=100, lo=0xFFFFFFFF.
5. Backpressure: hold out_ready=0 after ADD 3+4 -> result=7 held, in_ready=0, next op stalls. Raise out_ready -> next op accepted in that cycle.
6. Reset pulsed 10 cycles into MULTU -> next edge: busy=0, out_valid=0, hi=lo=0, in_ready=1. WIDTH=8 instance: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 edges.
